sha512_msg_pad: RTL



---
 rtl/sha512_msg_pad.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sha512_msg_pad.sv
// SHA-512 message padder: packs big-endian 64-bit message words into a
// 16-word block buffer. It appends the 0x80 marker, the zero fill and the
// 128-bit message bit length, and presents each 1024-bit block downstream.
// The one buffer is either loading/padding or presenting, never both.
module sha512_msg_pad (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_last,
    input  logic [3:0]  in_nbytes,
    output logic        blk_valid,
    input  logic        blk_ready,
    output logic [0:63] blk_w [0:15],
    output logic        blk_last
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_PAD,
        ST_OUT
    } state_t;

    localparam logic [63:0] PAD_MARK = 64'h8000_0000_0000_0000;

    state_t      r_state;
    logic [63:0] r_buf [0:15];
    logic [3:0]  r_idx;
    logic [63:0] r_cnt;        // message length in bytes, wraps mod 2^64
    logic        r_pad_done;   // 0x80 marker already placed
    logic        r_from_pad;   // current non-final block is followed by padding
    logic        r_blk_last;

    logic        w_accept;
    logic [3:0]  w_nb;
    logic [63:0] w_last_word;

    assign w_accept  = in_valid && (r_state == ST_LOAD);
    assign w_nb      = (in_nbytes > 4'd8) ? 4'd8 : in_nbytes;
    assign in_ready  = (r_state == ST_LOAD);
    assign blk_valid = (r_state == ST_OUT);
    assign blk_last  = r_blk_last;

    // Final word: keep the first n bytes, put the marker in byte n, zero the rest
    always_comb begin
        w_last_word = '0;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < w_nb) begin
                w_last_word[63-8*b -: 8] = in_data[63-8*b -: 8];
            end else if (4'(b) == w_nb) begin
                w_last_word[63-8*b -: 8] = 8'h80;
            end
        end
    end

    // Present the buffer directly as the block output
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            blk_w[i] = r_buf[i];
        end
    end

    // Load / pad / present control and buffer updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_LOAD;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_pad_done <= 1'b0;
            r_from_pad <= 1'b0;
            r_blk_last <= 1'b0;
            // NOTE: the buffer is reset too, because blk_w exposes it directly
            // and must read as zero out of reset with no stale message data.
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        if (!in_last) begin
                            r_buf[r_idx] <= in_data;
                            r_cnt        <= r_cnt + 64'd8;
                            if (r_idx == 4'd15) begin
                                r_idx      <= '0;
                                r_from_pad <= 1'b0;
                                r_blk_last <= 1'b0;
                                r_state    <= ST_OUT;
                            end else begin
                                r_idx <= r_idx + 4'd1;
                            end
                        end else begin
                            r_buf[r_idx] <= w_last_word;
                            r_cnt        <= r_cnt + 64'(w_nb);
                            r_pad_done   <= (w_nb < 4'd8);
                            r_idx        <= r_idx + 4'd1;
                            if (r_idx == 4'd15) begin
                                // Buffer full: ship it, the length goes in a following block
                                r_from_pad <= 1'b1;
                                r_blk_last <= 1'b0;
                                r_state    <= ST_OUT;
                            end else begin
                                r_state <= ST_PAD;
                            end
                        end
                    end
                end
                ST_PAD: begin
                    if ((r_idx == 4'd14) && r_pad_done) begin
                        r_buf[14]  <= {61'b0, r_cnt[63:61]};
                        r_buf[15]  <= {r_cnt[60:0], 3'b0};
                        r_blk_last <= 1'b1;
                        r_state    <= ST_OUT;
                    end else begin
                        r_buf[r_idx] <= r_pad_done ? 64'd0 : PAD_MARK;
                        r_pad_done   <= 1'b1;
                        r_idx        <= r_idx + 4'd1;
                        if (r_idx == 4'd15) begin
                            r_from_pad <= 1'b1;
                            r_blk_last <= 1'b0;
                            r_state    <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (blk_ready) begin
                        r_blk_last <= 1'b0;
                        if (r_blk_last) begin
                            r_state    <= ST_LOAD;
                            r_cnt      <= '0;
                            r_idx      <= '0;
                            r_pad_done <= 1'b0;
                        end else if (r_from_pad) begin
                            r_state <= ST_PAD;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

endmodule
